syzygy_camera_capture_ctrl: RTL and testbench
=============================================

# syzygy_camera_capture_ctrl

Frame capture sequencer between the SYZYGY camera HiSPi PHY and the downstream frame buffer writer. Consumes the PHY's deserialized pixel words and sync pulses, arms and sequences single or continuous frame captures, and checks line and frame geometry against programmed sizes. Forwards only words from complete, well-formed frames with start-of-frame and end-of-line markers. Runs entirely in the PHY's divided pixel clock domain.

## Interface
- `WORDS_W`, default 10: width of words-per-line count; one word is 4 pixels of 10 bits.
- `LINES_W`, default 12: width of lines-per-frame count.
- `FCNT_W`, default 16: width of the completed-frame counter.
- `clk`  in  1: PHY divided pixel clock.
- `reset_b`  in  1: **synchronous, active-low reset**.
- `capture_arm`  in  1: pulse; arms capture of the next frame.
- `capture_continuous`  in  1: level; re-arms automatically after each completed frame.
- `capture_abort`  in  1: pulse; abandons any capture in progress and returns to IDLE.
- `expected_words`  in  WORDS_W: words per line; 0 is illegal and is treated as 1.
- `expected_lines`  in  LINES_W: lines per frame; 0 is illegal and is treated as 1.
- `pix_data`  in  40: PHY pixel word.
- `line_valid`  in  1: PHY word valid.
- `sync_sof`, `sync_sol`, `sync_eol`, `sync_eof`, `sync_error`  in  1 each: PHY single-cycle sync pulses.
- `out_data`  out  40: forwarded word.
- `out_valid`  out  1: forwarded word is valid.
- `out_sof`  out  1: qualifies the first word of a frame.
- `out_eol`  out  1: qualifies the last word of each line.
- `out_ready`  in  1: sink can accept a word. The sink cannot stall the source; see overflow.
- `busy`  out  1: high in any state except IDLE.
- `frame_done`  out  1: one-cycle pulse when a frame completes.
- `frame_count`  out  FCNT_W: number of completed frames; wraps.
- `err_sync`, `err_geom`, `err_overflow`  out  1 each: sticky error flags.
- `err_clear`  in  1: pulse; clears the sticky error flags.

## Operation
- States:
  - IDLE
  - WAIT_SOF
  - LINE
  - GAP
- IDLE:
  - `capture_arm` moves to WAIT_SOF.
  - `capture_continuous` high also moves to WAIT_SOF.
- WAIT_SOF:
  - `sync_sof` clears the line counter and word counter, sets a first-word flag, and moves to GAP.
  - Every other input is ignored.
- GAP (between lines):
  - First `line_valid` moves to LINE and forwards that word.
  - `sync_eof` with `line_cnt == expected_lines` completes the frame.
  - `sync_eof` with any other line count sets `err_geom` and aborts.
- LINE:
  - Each `line_valid` word is forwarded and increments `word_cnt`.
  - On the word where `word_cnt == expected_words-1`: assert `out_eol`, clear `word_cnt`, increment `line_cnt`, go to GAP.
  - `line_valid` low before that word sets `err_geom` and aborts (short line).
  - A long line is detected in GAP: `line_valid` high on the cycle right after an eol word sets `err_geom` and aborts.
- Frame complete:
  - `frame_done` pulses and `frame_count` increments modulo 2^FCNT_W.
  - Next state is WAIT_SOF if `capture_continuous`, otherwise IDLE.
- Abort:
  - Next state is WAIT_SOF if `capture_continuous`, otherwise IDLE.
  - No further words are forwarded for the current frame.
- `sync_error` in GAP or LINE sets `err_sync` and aborts.
- `sync_sof` in GAP or LINE sets `err_sync`, abandons the current frame, and restarts as if in WAIT_SOF on that same pulse.
- Overflow: `out_valid && !out_ready` sets `err_overflow`, drops the word, and aborts.
- `capture_abort` has priority over every other event in every state and goes directly to IDLE.
- `capture_arm` outside IDLE is ignored.
- Priority within one cycle: `capture_abort` > `sync_error` > `sync_sof` > overflow > geometry > normal.
- `err_clear` clears the flags; a same-cycle new error wins (flag stays set).

## Timing
- Forwarding latency:
  - `out_data`, `out_valid`, `out_sof`, `out_eol` are registered, 1 cycle after the `pix_data`/`line_valid` sample.
  - `out_sof` and `out_eol` can both be high when `expected_words == 1`.
- `frame_done` asserts the cycle after `sync_eof` is sampled.
- State, counters and `busy` update on the clock edge after the causing input.
- `expected_words` and `expected_lines` are sampled once, on the `sync_sof` that starts a frame. Changes mid-frame have no effect.
- Reset (`reset_b` low at a clock edge):
  - State returns to IDLE.
  - Every output goes to 0: `out_data`, `out_valid`, `out_sof`, `out_eol`, `busy`, `frame_done`, `frame_count`, all error flags.
  - Counters go to 0.
  - Mid-frame reset discards the frame with no `frame_done` pulse.
- Counter widths: `word_cnt` is WORDS_W bits and `line_cnt` is LINES_W bits. Compares are equality only, so neither counter can overflow before a compare triggers.

## Structure
- Package `camera_capture_pkg` holds:
  - the state encoding (IDLE, WAIT_SOF, LINE, GAP);
  - the default width constants;
  - the error-bit index constants.
- Sub-module `camera_geom_counter`:
  - word and line counters with latched expected sizes;
  - outputs `last_word`, `last_line`, `short_line`;
  - instantiated once.
- Top level holds the FSM, output register, error flags and frame counter.

## Test plan
- Arm, `expected_words=4`, `expected_lines=3`, clean frame of 3×4 words → 12 `out_valid`; `out_sof` on word 0; `out_eol` on words 3, 7, 11; one `frame_done`; `frame_count=1`; back in IDLE.
- `capture_continuous=1` over 3 clean frames → `frame_count=3`, `busy` stays high, no errors.
- Second line has 3 words (`expected_words=4`) → `err_geom=1`, no `frame_done`, no further `out_valid` until the next armed `sync_sof`.
- `sync_error` mid-line, and separately `sync_sof` mid-frame → `err_sync=1`. The second case restarts the frame and completes with `frame_count=1`.
- `out_ready=0` on word 5 → `err_overflow=1`, capture aborted. `err_clear` then clears it. `err_clear` coincident with a new error leaves the flag at 1.
- `reset_b` low for 1 cycle mid-LINE → all outputs 0 the next cycle, IDLE. A subsequent arm captures a clean frame normally.

Source files
------------

// File: rtl/camera_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_capture_pkg
// Description : Shared state encoding, default widths and error-bit indices
//               for the SYZYGY camera frame capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_LINE     = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  localparam int WORDS_W_DEF = 10;
  localparam int LINES_W_DEF = 12;
  localparam int FCNT_W_DEF  = 16;
  localparam int PIX_W       = 40;   // one word = 4 pixels x 10 bits

  localparam int ERR_W    = 3;
  localparam int ERR_SYNC = 0;
  localparam int ERR_GEOM = 1;
  localparam int ERR_OVF  = 2;

endpackage
`default_nettype wire

// File: rtl/camera_geom_counter.sv
`default_nettype none
// ============================================================================
// Module      : camera_geom_counter
// Description : Word/line counters with frame sizes latched at start of frame.
//               Reports last word of a line, last line of a frame and a
//               line that ended early.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_geom_counter
  import camera_capture_pkg::*;
#(
  parameter int WORDS_W = WORDS_W_DEF,
  parameter int LINES_W = LINES_W_DEF
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               start_i,
  input  logic [WORDS_W-1:0] exp_words_i,
  input  logic [LINES_W-1:0] exp_lines_i,
  input  logic               word_en_i,
  input  logic               in_line_i,
  input  logic               line_valid_i,
  output logic               last_word_o,
  output logic               last_line_o,
  output logic               short_line_o
);

  logic [WORDS_W-1:0] exp_w_q, exp_w_d;
  logic [LINES_W-1:0] exp_l_q, exp_l_d;
  logic [WORDS_W-1:0] word_cnt_q, word_cnt_d;
  logic [LINES_W-1:0] line_cnt_q, line_cnt_d;

  // Latched sizes are never zero, so exp_w_q - 1 cannot underflow mid-frame.
  assign last_word_o  = (word_cnt_q == (exp_w_q - WORDS_W'(1)));
  assign last_line_o  = (line_cnt_q == exp_l_q);
  assign short_line_o = in_line_i && !line_valid_i;

  // Next-state: latch sizes on start, advance word/line on each accepted word.
  always_comb begin
    exp_w_d    = exp_w_q;
    exp_l_d    = exp_l_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    if (start_i) begin
      exp_w_d    = (exp_words_i == '0) ? WORDS_W'(1) : exp_words_i;
      exp_l_d    = (exp_lines_i == '0) ? LINES_W'(1) : exp_lines_i;
      word_cnt_d = '0;
      line_cnt_d = '0;
    end else if (word_en_i) begin
      if (last_word_o) begin
        word_cnt_d = '0;
        line_cnt_d = line_cnt_q + LINES_W'(1);
      end else begin
        word_cnt_d = word_cnt_q + WORDS_W'(1);
      end
    end
  end

  // Counter and size registers.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      exp_w_q    <= '0;
      exp_l_q    <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
    end else begin
      exp_w_q    <= exp_w_d;
      exp_l_q    <= exp_l_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/syzygy_camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : syzygy_camera_capture_ctrl
// Description : Frame capture sequencer between the HiSPi PHY and the frame
//               buffer writer. Arms single/continuous captures, checks line
//               and frame geometry, forwards words of well-formed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module syzygy_camera_capture_ctrl
  import camera_capture_pkg::*;
#(
  parameter int WORDS_W = WORDS_W_DEF,
  parameter int LINES_W = LINES_W_DEF,
  parameter int FCNT_W  = FCNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               capture_arm,
  input  logic               capture_continuous,
  input  logic               capture_abort,
  input  logic [WORDS_W-1:0] expected_words,
  input  logic [LINES_W-1:0] expected_lines,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               line_valid,
  input  logic               sync_sof,
  input  logic               sync_sol,
  input  logic               sync_eol,
  input  logic               sync_eof,
  input  logic               sync_error,
  output logic [PIX_W-1:0]   out_data,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eol,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [FCNT_W-1:0]  frame_count,
  output logic               err_sync,
  output logic               err_geom,
  output logic               err_overflow,
  input  logic               err_clear
);

  state_e              state_q, state_d;
  logic [PIX_W-1:0]    out_data_q;
  logic                out_valid_q, out_sof_q, out_eol_q;
  logic                first_q, just_eol_q, frame_done_q;
  logic [FCNT_W-1:0]   frame_count_q;
  logic [ERR_W-1:0]    err_q, err_set;

  logic   word_accept, cnt_start, frame_done_d;
  logic   last_word, last_line, short_line, overflow;
  state_e rest_state;

  // Line boundaries are derived from word counts, so SOL/EOL pulses carry no
  // extra information here.
  logic unused_sync;
  assign unused_sync = sync_sol ^ sync_eol;

  assign overflow   = out_valid_q && !out_ready;
  assign rest_state = capture_continuous ? ST_WAIT_SOF : ST_IDLE;

  camera_geom_counter #(
    .WORDS_W (WORDS_W),
    .LINES_W (LINES_W)
  ) u_geom (
    .clk          (clk),
    .reset_b      (reset_b),
    .start_i      (cnt_start),
    .exp_words_i  (expected_words),
    .exp_lines_i  (expected_lines),
    .word_en_i    (word_accept),
    .in_line_i    (state_q == ST_LINE),
    .line_valid_i (line_valid),
    .last_word_o  (last_word),
    .last_line_o  (last_line),
    .short_line_o (short_line)
  );

  // Sequencer: event priority is abort > sync_error > sof > overflow > geometry.
  always_comb begin
    state_d      = state_q;
    word_accept  = 1'b0;
    cnt_start    = 1'b0;
    frame_done_d = 1'b0;
    err_set      = '0;
    case (state_q)
      ST_IDLE: begin
        if (capture_arm || capture_continuous) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (sync_sof) begin
          cnt_start = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP, ST_LINE: begin
        if (sync_error) begin
          err_set[ERR_SYNC] = 1'b1;
          state_d           = rest_state;
        end else if (sync_sof) begin
          // Unexpected SOF: drop this frame and start a fresh one on this pulse.
          err_set[ERR_SYNC] = 1'b1;
          cnt_start         = 1'b1;
          state_d           = ST_GAP;
        end else if (overflow) begin
          err_set[ERR_OVF] = 1'b1;
          state_d          = rest_state;
        end else if (state_q == ST_LINE) begin
          if (short_line) begin
            err_set[ERR_GEOM] = 1'b1;
            state_d           = rest_state;
          end else begin
            word_accept = 1'b1;
            state_d     = last_word ? ST_GAP : ST_LINE;
          end
        end else begin
          if (just_eol_q && line_valid) begin
            // Word straight after the eol word: the line was too long.
            err_set[ERR_GEOM] = 1'b1;
            state_d           = rest_state;
          end else if (sync_eof) begin
            if (last_line) begin
              frame_done_d = 1'b1;
            end else begin
              err_set[ERR_GEOM] = 1'b1;
            end
            state_d = rest_state;
          end else if (line_valid) begin
            word_accept = 1'b1;
            state_d     = last_word ? ST_GAP : ST_LINE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture_abort) begin
      state_d      = ST_IDLE;
      word_accept  = 1'b0;
      cnt_start    = 1'b0;
      frame_done_d = 1'b0;
      err_set      = '0;
    end
  end

  // State, output word register, error flags and frame counter.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q       <= ST_IDLE;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      first_q       <= 1'b0;
      just_eol_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= word_accept;
      out_sof_q    <= word_accept && first_q;
      out_eol_q    <= word_accept && last_word;
      just_eol_q   <= word_accept && last_word;
      frame_done_q <= frame_done_d;
      if (word_accept) out_data_q <= pix_data;
      if (cnt_start) begin
        first_q <= 1'b1;
      end else if (word_accept) begin
        first_q <= 1'b0;
      end
      if (frame_done_d) frame_count_q <= frame_count_q + FCNT_W'(1);
      err_q <= (err_clear ? '0 : err_q) | err_set;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign out_eol      = out_eol_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_sync     = err_q[ERR_SYNC];
  assign err_geom     = err_q[ERR_GEOM];
  assign err_overflow = err_q[ERR_OVF];

endmodule
`default_nettype wire

// File: tb/tb_syzygy_camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_syzygy_camera_capture_ctrl
// Description : Directed, table-driven bench for the camera capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syzygy_camera_capture_ctrl;

  // Control bits of a stimulus record.
  localparam logic [9:0] C_RST  = 10'h200;
  localparam logic [9:0] C_ARM  = 10'h100;
  localparam logic [9:0] C_CONT = 10'h080;
  localparam logic [9:0] C_ABT  = 10'h040;
  localparam logic [9:0] C_SOF  = 10'h020;
  localparam logic [9:0] C_EOF  = 10'h010;
  localparam logic [9:0] C_SERR = 10'h008;
  localparam logic [9:0] C_LV   = 10'h004;
  localparam logic [9:0] C_NRDY = 10'h002;
  localparam logic [9:0] C_CLR  = 10'h001;
  // Expected {out_valid, out_sof, out_eol, frame_done}.
  localparam logic [3:0] XV = 4'h8;
  localparam logic [3:0] XS = 4'h4;
  localparam logic [3:0] XE = 4'h2;
  localparam logic [3:0] XD = 4'h1;
  // Expected {err_overflow, err_geom, err_sync}.
  localparam logic [2:0] EO = 3'b100;
  localparam logic [2:0] EG = 3'b010;
  localparam logic [2:0] ES = 3'b001;

  typedef struct packed {
    logic [9:0] ctl;
    logic [7:0] dat;
    logic [3:0] exo;
    logic       ebusy;
    logic [2:0] eerr;
    logic [7:0] efcnt;
    logic [7:0] edat;
  } vec_t;

  logic        clk, reset_b, capture_arm, capture_continuous, capture_abort;
  logic [9:0]  expected_words;
  logic [11:0] expected_lines;
  logic [39:0] pix_data, out_data;
  logic        line_valid, sync_sof, sync_sol, sync_eol, sync_eof, sync_error;
  logic        out_valid, out_sof, out_eol, out_ready, busy, frame_done;
  logic [15:0] frame_count;
  logic        err_sync, err_geom, err_overflow, err_clear;

  logic [9:0]  exp_w;
  logic [11:0] exp_l;
  logic        cont_lvl;
  int          n_pass, n_total, nvalid, busy_low;
  vec_t        tbl[$];

  syzygy_camera_capture_ctrl dut (
    .clk(clk), .reset_b(reset_b), .capture_arm(capture_arm),
    .capture_continuous(capture_continuous), .capture_abort(capture_abort),
    .expected_words(expected_words), .expected_lines(expected_lines),
    .pix_data(pix_data), .line_valid(line_valid), .sync_sof(sync_sof),
    .sync_sol(sync_sol), .sync_eol(sync_eol), .sync_eof(sync_eof),
    .sync_error(sync_error), .out_data(out_data), .out_valid(out_valid),
    .out_sof(out_sof), .out_eol(out_eol), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .err_sync(err_sync),
    .err_geom(err_geom), .err_overflow(err_overflow), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [9:0] c, input logic [7:0] d);
    reset_b            = ~c[9];
    capture_arm        = c[8];
    capture_continuous = c[7] | cont_lvl;
    capture_abort      = c[6];
    sync_sof           = c[5];
    sync_eof           = c[4];
    sync_error         = c[3];
    line_valid         = c[2];
    out_ready          = ~c[1];
    err_clear          = c[0];
    sync_sol           = c[5] | (c[2] & (d[1:0] == 2'd0));
    sync_eol           = c[2] & (d[1:0] == 2'd3);
    pix_data           = {5{d}};
    expected_words     = exp_w;
    expected_lines     = exp_l;
    @(posedge clk);
    #1;
    if (out_valid) nvalid++;
    if (!busy) busy_low++;
  endtask

  task automatic add(input logic [9:0] c, input logic [7:0] d, input logic [3:0] x,
                     input logic b, input logic [2:0] e, input logic [7:0] f,
                     input logic [7:0] ed);
    tbl.push_back('{ctl: c, dat: d, exo: x, ebusy: b, eerr: e, efcnt: f, edat: ed});
  endtask

  // Four-word line rows; words are numbered from base.
  task automatic add_line(input logic [7:0] base, input logic first, input logic [7:0] f);
    for (int w = 0; w < 4; w++)
      add(C_LV, base + 8'(w), XV | ((first && w == 0) ? XS : 4'h0) | ((w == 3) ? XE : 4'h0),
          1'b1, 3'b000, f, base + 8'(w));
  endtask

  // 3x4 frame body (SOF already sent); checks sof on word 0 and eol per line.
  task automatic frame_body(input string tag);
    for (int l = 0; l < 3; l++) begin
      for (int w = 0; w < 4; w++) begin
        step(C_LV, 8'(l * 4 + w));
        if (l == 0 && w == 0) chk({tag, " first word sof"}, {out_valid, out_sof}, 2'b11);
        if (w == 3) chk({tag, " eol"}, {out_valid, out_eol}, 2'b11);
      end
      step(10'h0, 8'h0);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; nvalid = 0; busy_low = 0;
    cont_lvl = 1'b0; exp_w = 10'd4; exp_l = 12'd3;
    reset_b = 1'b0; capture_arm = 0; capture_continuous = 0; capture_abort = 0;
    sync_sof = 0; sync_sol = 0; sync_eol = 0; sync_eof = 0; sync_error = 0;
    line_valid = 0; out_ready = 1; err_clear = 0; pix_data = '0;
    expected_words = exp_w; expected_lines = exp_l;

    // Reset, then a clean 3x4 frame.
    add(C_RST, 0, 0, 0, 0, 0, 0);
    add(C_RST, 0, 0, 0, 0, 0, 0);
    add(10'h0, 0, 0, 0, 0, 0, 0);
    add(C_ARM, 0, 0, 1, 0, 0, 0);
    add(C_SOF, 0, 0, 1, 0, 0, 0);
    add_line(8'd0, 1'b1, 8'd0);  add(10'h0, 0, 0, 1, 0, 0, 0);
    add_line(8'd4, 1'b0, 8'd0);  add(10'h0, 0, 0, 1, 0, 0, 0);
    add_line(8'd8, 1'b0, 8'd0);
    add(C_EOF, 0, XD, 0, 0, 1, 0);
    add(10'h0, 0, 0, 0, 0, 1, 0);
    // Long line: word right after eol.
    add(C_ARM, 0, 0, 1, 0, 1, 0);
    add(C_SOF, 0, 0, 1, 0, 1, 0);
    add_line(8'd0, 1'b1, 8'd1);
    add(C_LV, 8'd4, 0, 0, EG, 1, 0);
    add(C_CLR, 0, 0, 0, 0, 1, 0);
    // EOF after one line of three.
    add(C_ARM, 0, 0, 1, 0, 1, 0);
    add(C_SOF, 0, 0, 1, 0, 1, 0);
    add_line(8'd0, 1'b1, 8'd1);
    add(C_EOF, 0, 0, 0, EG, 1, 0);
    add(C_CLR, 0, 0, 0, 0, 1, 0);
    // Short second line, then nothing forwarded until an armed SOF.
    add(C_ARM, 0, 0, 1, 0, 1, 0);
    add(C_SOF, 0, 0, 1, 0, 1, 0);
    add_line(8'd0, 1'b1, 8'd1);  add(10'h0, 0, 0, 1, 0, 1, 0);
    add(C_LV, 8'd4, XV, 1, 0, 1, 8'd4);
    add(C_LV, 8'd5, XV, 1, 0, 1, 8'd5);
    add(C_LV, 8'd6, XV, 1, 0, 1, 8'd6);
    add(10'h0, 0, 0, 0, EG, 1, 0);
    add(C_LV, 8'd7, 0, 0, EG, 1, 0);
    add(C_SOF, 0, 0, 0, EG, 1, 0);
    add(C_LV, 8'd8, 0, 0, EG, 1, 0);
    add(C_ARM, 0, 0, 1, EG, 1, 0);
    add(C_LV, 8'd9, 0, 1, EG, 1, 0);
    add(C_SOF, 0, 0, 1, EG, 1, 0);
    add(C_LV, 8'd10, XV | XS, 1, EG, 1, 8'd10);
    add(C_ABT | C_LV, 8'd11, 0, 0, EG, 1, 0);
    add(C_CLR, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ctl, tbl[i].dat);
      chk($sformatf("row%0d v/sof/eol/done", i), {out_valid, out_sof, out_eol, frame_done}, tbl[i].exo);
      chk($sformatf("row%0d busy", i), busy, tbl[i].ebusy);
      chk($sformatf("row%0d errs", i), {err_overflow, err_geom, err_sync}, tbl[i].eerr);
      chk($sformatf("row%0d frame_count", i), frame_count, tbl[i].efcnt);
      if (tbl[i].exo[3]) chk($sformatf("row%0d data", i), out_data, {5{tbl[i].edat}});
    end

    // Continuous capture over three frames: busy never drops.
    cont_lvl = 1'b1;
    step(10'h0, 8'h0);
    chk("cont armed busy", busy, 1'b1);
    nvalid = 0; busy_low = 0;
    for (int f = 0; f < 3; f++) begin
      step(C_SOF, 8'h0);
      frame_body("cont");
      step(C_EOF, 8'h0);
      chk("cont frame_done", frame_done, 1'b1);
    end
    chk("cont frame_count", frame_count, 16'd4);
    chk("cont word count", nvalid, 36);
    chk("cont busy never low", busy_low, 0);
    chk("cont errs", {err_overflow, err_geom, err_sync}, 3'b000);
    cont_lvl = 1'b0;
    step(C_ABT, 8'h0);
    chk("cont abort idle", busy, 1'b0);

    // Reset in the middle of a line.
    step(C_ARM, 8'h0); step(C_SOF, 8'h0); step(C_LV, 8'h1); step(C_LV, 8'h2);
    step(C_RST | C_LV, 8'h3);
    chk("reset outputs", {out_valid, out_sof, out_eol, busy, frame_done}, 5'b0);
    chk("reset frame_count", frame_count, 16'd0);
    chk("reset out_data", out_data, 40'h0);
    step(10'h0, 8'h0);
    step(C_ARM, 8'h0); step(C_SOF, 8'h0);
    frame_body("post-reset");
    step(C_EOF, 8'h0);
    chk("post-reset done", {frame_done, busy}, 2'b10);
    chk("post-reset frame_count", frame_count, 16'd1);

    // SOF in mid-frame restarts the frame.
    step(C_RST, 8'h0); step(10'h0, 8'h0);
    step(C_ARM, 8'h0); step(C_SOF, 8'h0);
    for (int w = 0; w < 4; w++) step(C_LV, 8'(w));
    step(10'h0, 8'h0);
    step(C_SOF, 8'h0);
    chk("restart err_sync/busy/valid", {err_sync, busy, out_valid}, 3'b110);
    frame_body("restart");
    step(C_EOF, 8'h0);
    chk("restart done", frame_done, 1'b1);
    chk("restart frame_count", frame_count, 16'd1);

    // Overflow on word 5, clear, then clear racing a new error.
    step(C_CLR, 8'h0);
    chk("clear sync", {err_overflow, err_geom, err_sync}, 3'b000);
    step(C_ARM, 8'h0); step(C_SOF, 8'h0);
    for (int w = 0; w < 4; w++) step(C_LV, 8'(w));
    step(10'h0, 8'h0);
    step(C_LV, 8'd4);
    step(C_LV, 8'd5);
    chk("word5 presented", out_data, {5{8'd5}});
    step(C_LV | C_NRDY, 8'd6);
    chk("overflow flag", {err_overflow, err_geom, err_sync}, EO);
    chk("overflow aborted", {busy, out_valid}, 2'b00);
    step(C_LV, 8'd7);
    chk("overflow no forward", out_valid, 1'b0);
    step(C_CLR, 8'h0);
    chk("overflow cleared", {err_overflow, err_geom, err_sync}, 3'b000);
    step(C_ARM, 8'h0); step(C_SOF, 8'h0); step(C_LV, 8'h0);
    step(C_SERR | C_CLR, 8'h0);
    chk("clr vs new sync err", {err_overflow, err_geom, err_sync}, ES);
    step(C_ARM, 8'h0); step(C_SOF, 8'h0);
    step(C_SERR | C_CLR, 8'h0);
    chk("clr vs repeat sync err", {err_overflow, err_geom, err_sync}, ES);

    // Zero sizes act as 1x1; mid-frame size changes are ignored.
    step(C_CLR, 8'h0);
    exp_w = 10'd0; exp_l = 12'd0;
    step(C_ARM, 8'h0); step(C_SOF, 8'h0);
    exp_w = 10'd4; exp_l = 12'd3;
    step(C_LV, 8'h5A);
    chk("1x1 sof+eol", {out_valid, out_sof, out_eol}, 3'b111);
    chk("1x1 data", out_data, {5{8'h5A}});
    step(C_EOF, 8'h0);
    chk("1x1 done", {frame_done, busy}, 2'b10);
    chk("1x1 frame_count", frame_count, 16'd2);
    chk("1x1 errs", {err_overflow, err_geom, err_sync}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
